// File: rtl/multicycle_control_fsm_if.sv
// Shared instruction/data memory port between the sequencer and memory.
// The sequencer drives the strobes; memory answers with memReady.
`ifndef ALU_AND
`define ALU_AND   3'b000
`define ALU_OR    3'b001
`define ALU_ADD   3'b010
`define ALU_UNDEF 3'b011
`define ALU_SUB   3'b110
`define ALU_SLT   3'b111
`endif

interface multicycle_control_fsm_if;
  logic memReady;
  logic memRead;
  logic memWrite;
  logic memAddrSel;

  modport master (
    input  memReady,
    output memRead,
    output memWrite,
    output memAddrSel
  );

  modport slave (
    output memReady,
    input  memRead,
    input  memWrite,
    input  memAddrSel
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS32 sequencer: FETCH/DECODE/EXEC/MEM/WB over one
// shared memory port, with wait timeout, sticky traps and retire count.
`ifndef ALU_AND
`define ALU_AND   3'b000
`define ALU_OR    3'b001
`define ALU_ADD   3'b010
`define ALU_UNDEF 3'b011
`define ALU_SUB   3'b110
`define ALU_SLT   3'b111
`endif

module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opc,
  input  logic [5:0]  func,
  input  logic        zero,
  multicycle_control_fsm_if.master mem,
  output logic [2:0]  state,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        irWrite,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluFunc,
  output logic        rfWriteEnable,
  output logic        rfWriteAddrSel,
  output logic [1:0]  rfWriteDataSel,
  output logic        invOpcode,
  output logic        memErr,
  output logic        halted,
  output logic [31:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [5:0]  fn_q, fn_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] retired_q, retired_d;
  logic        inv_q, inv_d;
  logic        merr_q, merr_d;

  logic [5:0] op;
  logic [5:0] fn;
  logic [2:0] r_alu;
  logic       r_ok;
  logic       is_r, is_j, is_beq, is_bne;
  logic       is_lw, is_sw, legal;
  logic       waiting, tmo, retire;
  logic [2:0] boundary;
  logic       mem_rd, mem_wr, mem_as;

  // IR is valid in DECODE; later states see only the latched copy
  assign op = (state_q == S_DECODE) ? opc : op_q;
  assign fn = (state_q == S_DECODE) ? func : fn_q;

  assign is_r   = (op == OP_R);
  assign is_j   = (op == OP_J);
  assign is_beq = (op == OP_BEQ);
  assign is_bne = (op == OP_BNE);
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);

  always_comb begin
    r_alu = `ALU_UNDEF;
    r_ok  = 1'b0;
    case (fn)
      6'h20: begin r_alu = `ALU_ADD; r_ok = 1'b1; end
      6'h22: begin r_alu = `ALU_SUB; r_ok = 1'b1; end
      6'h24: begin r_alu = `ALU_AND; r_ok = 1'b1; end
      6'h25: begin r_alu = `ALU_OR;  r_ok = 1'b1; end
      6'h2A: begin r_alu = `ALU_SLT; r_ok = 1'b1; end
      default: ;
    endcase
  end

  assign legal = (is_r & r_ok) | is_j | is_beq
               | is_bne | is_lw | is_sw;

  assign waiting  = (state_q == S_FETCH) | (state_q == S_MEM);
  assign tmo      = waiting & ~mem.memReady & (wait_q == TMO_LAST);
  assign boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d        = state_q;
    inv_d          = inv_q;
    merr_d         = merr_q;
    retire         = 1'b0;
    pcWrite        = 1'b0;
    pcSrc          = 2'd0;
    irWrite        = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_as         = 1'b0;
    aluSrcA        = 1'b0;
    aluSrcB        = 2'd0;
    aluFunc        = `ALU_UNDEF;
    rfWriteEnable  = 1'b0;
    rfWriteAddrSel = 1'b0;
    rfWriteDataSel = 2'd0;
    halted         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        aluSrcB = 2'd1;
        aluFunc = `ALU_ADD;
        if (mem.memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          merr_d  = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        aluSrcB = 2'd3;
        aluFunc = `ALU_ADD;
        if (!legal) begin
          inv_d   = 1'b1;
          state_d = S_TRAP;
        end else if (is_j) begin
          pcWrite = 1'b1;
          pcSrc   = 2'd2;
          retire  = 1'b1;
          state_d = boundary;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        unique case (1'b1)
          is_r: begin
            aluFunc = r_alu;
            state_d = S_WB;
          end
          is_lw, is_sw: begin
            aluSrcB = 2'd2;
            aluFunc = `ALU_ADD;
            state_d = S_MEM;
          end
          default: begin
            aluFunc = `ALU_SUB;
            pcSrc   = 2'd1;
            pcWrite = is_beq ? zero : ~zero;
            retire  = 1'b1;
            state_d = boundary;
          end
        endcase
      end
      S_MEM: begin
        mem_as = 1'b1;
        mem_rd = is_lw;
        mem_wr = is_sw;
        if (mem.memReady) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = boundary;
          end
        end else if (tmo) begin
          merr_d  = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        rfWriteEnable = 1'b1;
        if (is_lw) rfWriteDataSel = 2'd1;
        else       rfWriteAddrSel = 1'b1;
        retire  = 1'b1;
        state_d = boundary;
      end
      S_TRAP: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    op_d      = (state_q == S_DECODE) ? opc : op_q;
    fn_d      = (state_q == S_DECODE) ? func : fn_q;
    retired_d = retired_q + {31'd0, retire};
    wait_d    = 8'd0;
    if (waiting && !mem.memReady && state_d == state_q)
      wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= 6'd0;
      fn_q      <= 6'd0;
      wait_q    <= 8'd0;
      retired_q <= 32'd0;
      inv_q     <= 1'b0;
      merr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      inv_q     <= inv_d;
      merr_q    <= merr_d;
    end
  end

  assign mem.memRead    = mem_rd;
  assign mem.memWrite   = mem_wr;
  assign mem.memAddrSel = mem_as;
  assign state          = state_q;
  assign invOpcode      = inv_q;
  assign memErr         = merr_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction table, hand-written
// corner sequences and randomized traffic against a phase-list model.
module tb_multicycle_control_fsm;

  localparam logic [2:0] A_AND   = 3'd0;
  localparam logic [2:0] A_OR    = 3'd1;
  localparam logic [2:0] A_ADD   = 3'd2;
  localparam logic [2:0] A_UNDEF = 3'd3;
  localparam logic [2:0] A_SUB   = 3'd6;
  localparam logic [2:0] A_SLT   = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [5:0]  opc;
  logic [5:0]  func;
  logic        zero;
  logic [2:0]  state;
  logic        pcWrite;
  logic [1:0]  pcSrc;
  logic        irWrite;
  logic        aluSrcA;
  logic [1:0]  aluSrcB;
  logic [2:0]  aluFunc;
  logic        rfWriteEnable;
  logic        rfWriteAddrSel;
  logic [1:0]  rfWriteDataSel;
  logic        invOpcode;
  logic        memErr;
  logic        halted;
  logic [31:0] retired;

  multicycle_control_fsm_if mif();

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run),
    .opc(opc), .func(func), .zero(zero),
    .mem(mif),
    .state(state), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .irWrite(irWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluFunc(aluFunc), .rfWriteEnable(rfWriteEnable),
    .rfWriteAddrSel(rfWriteAddrSel),
    .rfWriteDataSel(rfWriteDataSel),
    .invOpcode(invOpcode), .memErr(memErr),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  logic [63:0] dut_vec;
  assign dut_vec = {20'd0, state, mif.memRead, mif.memWrite,
                    mif.memAddrSel, irWrite, pcWrite,
                    rfWriteEnable, aluFunc, retired};

  // Phase codes: 0 idle, 1 fetch, 2 decode, 3 exec, 4 mem, 5 wb.
  // Classes: 0 R, 1 LW, 2 SW, 3 BEQ, 4 BNE, 5 J.
  function automatic logic [63:0] model_vec(
      input int ph, input int cls, input logic [5:0] fn,
      input logic rdy, input logic z, input logic [31:0] ret);
    logic mrd, mwr, mas, irw, pcw, rfw;
    logic [2:0] alu;
    mrd = (ph == 1) || (ph == 4 && cls == 1);
    mwr = (ph == 4 && cls == 2);
    mas = (ph == 4);
    irw = (ph == 1) && rdy;
    pcw = ((ph == 1) && rdy) || (ph == 2 && cls == 5)
       || (ph == 3 && cls == 3 && z)
       || (ph == 3 && cls == 4 && !z);
    rfw = (ph == 5);
    alu = A_UNDEF;
    if (ph == 1 || ph == 2) alu = A_ADD;
    if (ph == 3) begin
      if (cls == 1 || cls == 2) alu = A_ADD;
      else if (cls == 3 || cls == 4) alu = A_SUB;
      else if (cls == 0) begin
        case (fn)
          6'h20: alu = A_ADD;
          6'h22: alu = A_SUB;
          6'h24: alu = A_AND;
          6'h25: alu = A_OR;
          default: alu = A_SLT;
        endcase
      end
    end
    return {20'd0, 3'(ph), mrd, mwr, mas, irw, pcw, rfw, alu, ret};
  endfunction

  logic [31:0] exp_ret;

  task automatic rcyc(input int ph, input int cls,
                      input logic [5:0] fn, input logic rdy);
    mif.memReady = rdy;
    zero = 1'($urandom);
    run  = 1'($urandom);
    if (ph != 2) begin
      opc  = 6'($urandom);
      func = 6'($urandom);
    end
    @(negedge clk);
    chk("rand_cycle", dut_vec,
        model_vec(ph, cls, fn, rdy, zero, exp_ret));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    mif.memReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [5:0] opc;
    logic [5:0] func;
    logic       zero;
    int         cycles;
    logic       inv;
    logic [2:0] alu;
    logic       pcw;
  } vec_t;

  vec_t tv[14];
  int   exp_st[6];
  logic [5:0] opcs[6];
  logic [5:0] rfns[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, cls, zeros;
    logic [2:0] alu_e;
    logic pcw_e, rdy, dsel, asel;
    logic [5:0] fn;

    tv[0]  = '{6'h00, 6'h20, 1'b0, 4, 1'b0, A_ADD,   1'b0};
    tv[1]  = '{6'h00, 6'h22, 1'b1, 4, 1'b0, A_SUB,   1'b0};
    tv[2]  = '{6'h00, 6'h24, 1'b0, 4, 1'b0, A_AND,   1'b0};
    tv[3]  = '{6'h00, 6'h25, 1'b0, 4, 1'b0, A_OR,    1'b0};
    tv[4]  = '{6'h00, 6'h2A, 1'b0, 4, 1'b0, A_SLT,   1'b0};
    tv[5]  = '{6'h23, 6'h00, 1'b0, 5, 1'b0, A_ADD,   1'b0};
    tv[6]  = '{6'h2B, 6'h11, 1'b0, 4, 1'b0, A_ADD,   1'b0};
    tv[7]  = '{6'h02, 6'h00, 1'b0, 2, 1'b0, A_UNDEF, 1'b0};
    tv[8]  = '{6'h04, 6'h00, 1'b1, 3, 1'b0, A_SUB,   1'b1};
    tv[9]  = '{6'h04, 6'h00, 1'b0, 3, 1'b0, A_SUB,   1'b0};
    tv[10] = '{6'h05, 6'h00, 1'b1, 3, 1'b0, A_SUB,   1'b0};
    tv[11] = '{6'h05, 6'h00, 1'b0, 3, 1'b0, A_SUB,   1'b1};
    tv[12] = '{6'h3F, 6'h20, 1'b0, 2, 1'b1, A_UNDEF, 1'b0};
    tv[13] = '{6'h00, 6'h27, 1'b0, 2, 1'b1, A_UNDEF, 1'b0};
    exp_st = '{0, 1, 2, 3, 5, 1};
    opcs   = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    rfns   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    opc = 6'd0; func = 6'd0; zero = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_reset();
      chk("reset_outputs", dut_vec,
          {20'd0, 3'd0, 6'd0, A_UNDEF, 32'd0});
      opc = tv[i].opc; func = tv[i].func; zero = tv[i].zero;
      run = 1'b1; mif.memReady = 1'b1;
      @(posedge clk); #1;
      n = 0; alu_e = A_UNDEF; pcw_e = 1'b0;
      while (retired == 0 && !halted && n < 20) begin
        @(negedge clk);
        if (state == 3'd3) begin
          alu_e = aluFunc;
          pcw_e = pcWrite;
        end
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("tv%0d_cycles", i), 64'(n), 64'(tv[i].cycles));
      chk($sformatf("tv%0d_inv", i), 64'(invOpcode), 64'(tv[i].inv));
      chk($sformatf("tv%0d_halted", i), 64'(halted), 64'(tv[i].inv));
      chk($sformatf("tv%0d_retired", i), 64'(retired),
          64'(!tv[i].inv));
      chk($sformatf("tv%0d_exec_alu", i), 64'(alu_e), 64'(tv[i].alu));
      chk($sformatf("tv%0d_exec_pcw", i), 64'(pcw_e), 64'(tv[i].pcw));
    end

    // ADD: exact state walk, write strobe only in WB
    do_reset();
    opc = 6'h00; func = 6'h20; zero = 1'b0;
    run = 1'b1; mif.memReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("add_state%0d", i), 64'(state), 64'(exp_st[i]));
      chk($sformatf("add_rfwe%0d", i), 64'(rfWriteEnable),
          64'(exp_st[i] == 5));
      if (i == 4) chk("add_wb_addrsel", 64'(rfWriteAddrSel), 64'd1);
      @(posedge clk); #1;
    end
    chk("add_retired", 64'(retired), 64'd1);

    // LW with three memory stall cycles
    do_reset();
    opc = 6'h23; func = 6'h00; run = 1'b1; mif.memReady = 1'b1;
    @(posedge clk); #1;
    n = 0; m = 0; zeros = 0; dsel = 1'b0; asel = 1'b1;
    while (retired == 0 && !halted && n < 30) begin
      if (state == 3'd4 && zeros < 3) begin
        mif.memReady = 1'b0; zeros++;
      end else begin
        mif.memReady = 1'b1;
      end
      @(negedge clk);
      if (mif.memRead && mif.memAddrSel) m++;
      if (state == 3'd5) begin
        dsel = rfWriteDataSel[0]; asel = rfWriteAddrSel;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("lw_cycles", 64'(n), 64'd8);
    chk("lw_mem_hold", 64'(m), 64'd4);
    chk("lw_wb_datasel", 64'(dsel), 64'd1);
    chk("lw_wb_addrsel", 64'(asel), 64'd0);

    // Illegal opcode: trap persists, only reset exits
    do_reset();
    opc = 6'h3F; run = 1'b1; mif.memReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    repeat (10) begin
      mif.memReady = 1'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("trap_persist", dut_vec, {20'd0, 3'd6, 6'd0, A_UNDEF, 32'd0});
    chk("trap_inv", 64'({invOpcode, halted, memErr}), 64'b110);
    rst = 1'b0; #1;
    chk("trap_reset", 64'({invOpcode, halted, state}), 64'd0);
    @(negedge clk); rst = 1'b1;

    // Fetch timeout after four idle memory cycles
    do_reset();
    opc = 6'h00; func = 6'h20; run = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (state == 3'd1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("tmo_wait_cycles", 64'(n), 64'd4);
    chk("tmo_state", 64'(state), 64'd6);
    chk("tmo_memerr", 64'(memErr), 64'd1);

    // Ready on the last allowed cycle beats the timeout
    do_reset();
    run = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    mif.memReady = 1'b1;
    @(posedge clk); #1;
    chk("tmo_edge_state", 64'(state), 64'd2);
    chk("tmo_edge_memerr", 64'(memErr), 64'd0);

    // SW completes with run dropped in MEM, then parks
    do_reset();
    opc = 6'h2B; run = 1'b1; mif.memReady = 1'b1;
    n = 0;
    while (state != 3'd4 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("sw_reach_mem", 64'(state), 64'd4);
    mif.memReady = 1'b0;
    @(posedge clk); #1;
    run = 1'b0; mif.memReady = 1'b1;
    @(negedge clk);
    chk("sw_mem_write", 64'(mif.memWrite), 64'd1);
    @(posedge clk); #1;
    chk("sw_idle_state", 64'(state), 64'd0);
    chk("sw_retired", 64'(retired), 64'd1);

    // Async reset mid-fetch drops strobes without a clock edge
    do_reset();
    run = 1'b1;
    @(posedge clk); #1;
    chk("fetch_memread", 64'(mif.memRead), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", dut_vec, {20'd0, 3'd0, 6'd0, A_UNDEF, 32'd0});
    @(negedge clk); rst = 1'b1;

    // Randomized traffic against the phase-list model
    do_reset();
    exp_ret = 32'd0;
    while (!run) rcyc(0, 0, 6'd0, 1'($urandom));
    for (int k = 0; k < 200; k++) begin
      cls = int'($urandom_range(0, 5));
      fn = (cls == 0) ? rfns[$urandom_range(0, 4)] : 6'($urandom);
      zeros = 0;
      do begin
        rdy = (zeros == 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (!rdy) zeros++;
        rcyc(1, cls, fn, rdy);
      end while (!rdy);
      opc = opcs[cls]; func = fn;
      rcyc(2, cls, fn, 1'($urandom));
      if (cls != 5) rcyc(3, cls, fn, 1'($urandom));
      if (cls == 1 || cls == 2) begin
        zeros = 0;
        do begin
          rdy = (zeros == 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
          if (!rdy) zeros++;
          rcyc(4, cls, fn, rdy);
        end while (!rdy);
      end
      if (cls == 0 || cls == 1) rcyc(5, cls, fn, 1'($urandom));
      exp_ret++;
      while (!run) rcyc(0, cls, fn, 1'($urandom));
    end
    chk("rand_retired", 64'(retired), 64'(exp_ret));
    chk("rand_no_err", 64'({invOpcode, memErr}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS32 SOC core. It replaces single-cycle control with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory port with a ready handshake.
- Supports ADD, SUB, AND, OR, SLT, J, BEQ, BNE, LW and SW.
- Drives PC, IR, register file, ALU mux and memory strobes. Also provides a bounded memory-wait timeout, a sticky trap and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive cycles the block waits for memReady before trapping. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- run  in  1  1 = execute instructions; 0 = park in IDLE at the next instruction boundary
- opc  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- memReady  in  1  memory completes the current access this cycle
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6
- pcWrite  out  1  PC load enable
- pcSrc  out  2  0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump target
- irWrite  out  1  IR load enable
- memAddrSel  out  1  0 = PC, 1 = ALUOut
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- aluSrcA  out  1  0 = PC, 1 = rs
- aluSrcB  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
- aluFunc  out  3  `ALU_* encoding; `ALU_UNDEF when unused
- rfWriteEnable  out  1  register file write enable
- rfWriteAddrSel  out  1  0 = rt, 1 = rd
- rfWriteDataSel  out  2  0 = ALUOut, 1 = memory data
- invOpcode  out  1  sticky: unsupported opc/func decoded
- memErr  out  1  sticky: memory timeout
- halted  out  1  1 while in TRAP
- retired  out  32  count of completed instructions

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; retired=0; invOpcode, memErr and wait counter cleared.
  - All strobes 0; selects 0; aluFunc=`ALU_UNDEF.
- Outputs are combinational from state and the latched opcode. Exceptions: pcWrite/irWrite in FETCH and the BEQ/BNE pcWrite in EXEC also depend on inputs (Mealy).
- Defaults in every state: all enables 0, selects 0, aluFunc=`ALU_UNDEF.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - memRead=1, memAddrSel=0, aluSrcA=0, aluSrcB=1, aluFunc=`ALU_ADD, pcSrc=0.
  - memRead is held until memReady=1.
  - In the memReady cycle: irWrite=1, pcWrite=1, next state DECODE.
- DECODE:
  - Latch opc/func into internal registers; EXEC/MEM/WB use only the latched copy.
  - aluSrcA=0, aluSrcB=3, aluFunc=`ALU_ADD (branch target into ALUOut).
  - Unsupported opc, or opc=0 with unsupported func -> TRAP with invOpcode=1.
  - J: pcWrite=1, pcSrc=2, retired+1, then go to the boundary target.
  - Any other legal opcode -> EXEC.
- EXEC:
  - R-type: aluSrcA=1, aluSrcB=0, aluFunc from func (ADD/SUB/AND/OR/SLT) -> WB.
  - LW/SW: aluSrcA=1, aluSrcB=2, `ALU_ADD -> MEM.
  - BEQ/BNE: aluSrcA=1, aluSrcB=0, `ALU_SUB, pcSrc=1.
    - pcWrite = zero for BEQ, ~zero for BNE.
    - retired+1, then go to the boundary target.
- MEM:
  - memAddrSel=1; memRead (LW) or memWrite (SW) held until memReady=1.
  - LW -> WB.
  - SW: retired+1, then go to the boundary target.
- WB:
  - rfWriteEnable=1 for exactly one cycle.
  - R-type: rfWriteAddrSel=1, rfWriteDataSel=0.
  - LW: rfWriteAddrSel=0, rfWriteDataSel=1.
  - retired+1, then go to the boundary target.
- Boundary target: FETCH if run=1, else IDLE. run is sampled only at instruction boundaries and in IDLE.
- Timeout:
  - An 8-bit wait counter increments each FETCH/MEM cycle with memReady=0 and clears on memReady=1 or on state change.
  - When the counter reaches MEM_TIMEOUT with memReady still 0 -> TRAP with memErr=1.
  - memReady=1 in that same cycle wins: no trap.
- TRAP: all strobes 0, halted=1; the only exit is reset. invOpcode and memErr stay set.
- retired wraps modulo 2^32.
- Reset mid-access: strobes drop immediately (async). No partial register-file write occurs.

Test Plan:
1. Reset, run=1, ADD (opc=0x00, func=0x20), memReady=1 always -> state 1,2,3,5,1. rfWriteEnable=1 only in WB with rfWriteAddrSel=1, aluFunc=`ALU_ADD in EXEC. retired=1 after 4 cycles.
2. LW (0x23) with memReady delayed 3 cycles in MEM -> memRead and memAddrSel=1 held 4 cycles. WB has rfWriteDataSel=1, rfWriteAddrSel=0. Instruction completes in 8 cycles total.
3. BEQ (0x04) zero=1 -> pcWrite=1, pcSrc=1 in EXEC. BNE (0x05) zero=1 -> pcWrite=0. Each retires in 3 cycles.
4. opc=0x3F, or opc=0 with func=0x27 -> TRAP in the cycle after DECODE. invOpcode=1, halted=1, retired unchanged. Persists until rst=0.
5. MEM_TIMEOUT=4 with memReady=0 in FETCH -> TRAP after 4 wait cycles with memErr=1. Repeat with memReady=1 on the 4th cycle -> DECODE, no error.
6. run dropped during an SW in MEM -> SW completes, state goes to IDLE, retired+1. Asserting rst=0 mid-FETCH -> IDLE and all strobes 0 with no clock edge.
